// File: rtl/apb4_regfile_pkg.sv
// Shared types and helpers for the APB4 register-file completer.
// Merge helpers are sized for the widest supported bus (32 bits); narrower buses zero-extend.
package apb4_regfile_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int STRB_WIDTH  = 4;
  localparam int OFFSET_BITS = $clog2(STRB_WIDTH);
  localparam int MERGE_W     = 8 * STRB_WIDTH;
  localparam int WCNT_WIDTH  = 4;

  function automatic logic [MERGE_W-1:0] strb_merge(
    input logic [MERGE_W-1:0]    old_v,
    input logic [MERGE_W-1:0]    new_v,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [MERGE_W-1:0] res;
    res = old_v;
    for (int k = 0; k < STRB_WIDTH; k++) begin
      if (strb[k]) res[8*k +: 8] = new_v[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb4_regfile_completer_if.sv
// APB4 completer bus bundle; the requester drives address/control/data, the completer answers.
// No storage here: timing and backpressure (pready) belong to the completer.
interface apb4_regfile_completer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_completer_fsm.sv
// APB4 IDLE/SETUP/ACCESS sequencer with wait counter; pready/pslverr registered, one-cycle pulse.
// First ACCESS cycle has pready high when WAIT_STATES=0; each extra wait state holds pready low a cycle.
module apb4_completer_fsm
  import apb4_regfile_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic preset_n,
  input  logic psel,
  input  logic penable,
  input  logic err,
  output logic pready,
  output logic pslverr,
  output logic ready_nxt,
  output logic commit
);

  localparam logic [WCNT_WIDTH-1:0] WAIT_LIM = WCNT_WIDTH'(WAIT_STATES);

  state_t                state, state_d;
  logic [WCNT_WIDTH-1:0] wcnt, wcnt_d;

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      state   <= IDLE;
      wcnt    <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      state   <= state_d;
      wcnt    <= wcnt_d;
      pready  <= ready_nxt;
      pslverr <= ready_nxt && err;
    end
  end

  always_comb begin
    state_d   = state;
    wcnt_d    = '0;
    ready_nxt = 1'b0;
    commit    = (state == ACCESS) && pready && psel && penable;

    case (state)
      IDLE: begin
        if (psel && !penable) state_d = SETUP;
      end
      SETUP: begin
        if (!psel)        state_d = IDLE;
        else if (penable) state_d = ACCESS;
      end
      ACCESS: begin
        if (pready)     state_d = (psel && !penable) ? SETUP : IDLE;
        else if (!psel) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Counter restarts at 0 on entry to ACCESS, so the response lands WAIT_STATES cycles later.
    if (state_d == ACCESS) begin
      if (state == ACCESS) wcnt_d = (wcnt == WAIT_LIM) ? wcnt : wcnt + 1'b1;
      ready_nxt = (wcnt_d == WAIT_LIM);
    end
  end

endmodule

// File: rtl/apb4_regfile_completer.sv
// APB4 register bank of NUM_REGS words with byte strobes, RO mask, error decode and hardware update port.
// Latency: 1 + WAIT_STATES cycles from SETUP to pready; writes visible on reg_q the cycle after completion.
module apb4_regfile_completer
  import apb4_regfile_pkg::*;
#(
  parameter int                  ADDR_WIDTH  = 16,
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  NUM_REGS    = 8,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                           clk,
  input  logic                           preset_n,
  apb4_regfile_completer_if.slave        bus,
  input  logic [NUM_REGS-1:0]            hw_we,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(STRB_W - 1);

  logic [ADDR_WIDTH-1:0] idx_full;
  logic [IDX_W-1:0]      idx;
  logic                  in_range, misaligned, ro_hit, err;
  logic                  ready_nxt, commit, apb_we;

  logic [DATA_WIDTH-1:0] regs    [NUM_REGS];
  logic [DATA_WIDTH-1:0] hw_next [NUM_REGS];
  logic [DATA_WIDTH-1:0] reg_d   [NUM_REGS];

  assign idx_full   = bus.paddr >> OFF_W;
  assign idx        = idx_full[IDX_W-1:0];
  assign in_range   = idx_full < ADDR_WIDTH'(NUM_REGS);
  assign misaligned = (bus.paddr & OFF_MASK) != '0;
  assign ro_hit     = bus.pwrite && in_range && RO_MASK[idx];
  assign err        = !in_range || misaligned || ro_hit;

  apb4_completer_fsm #(
    .WAIT_STATES(WAIT_STATES)
  ) u_fsm (
    .clk      (clk),
    .preset_n (preset_n),
    .psel     (bus.psel),
    .penable  (bus.penable),
    .err      (err),
    .pready   (bus.pready),
    .pslverr  (bus.pslverr),
    .ready_nxt(ready_nxt),
    .commit   (commit)
  );

  assign apb_we = commit && bus.pwrite && !err;

  // Hardware value forms the base; APB strobed bytes override it on a same-cycle collision.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      hw_next[i] = hw_we[i] ? hw_wdata[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
      reg_d[i]   = hw_next[i];
      if (apb_we && (idx == IDX_W'(i))) begin
        reg_d[i] = DATA_WIDTH'(strb_merge(MERGE_W'(hw_next[i]), MERGE_W'(bus.pwdata),
                                          STRB_WIDTH'(bus.pstrb)));
      end
    end
  end

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= reg_d[i];
    end
  end

  // Read data captured alongside pready so it reflects the pre-update register value.
  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) bus.prdata <= '0;
    else           bus.prdata <= (ready_nxt && !err && !bus.pwrite) ? regs[idx] : '0;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule
